// File: rtl/stepctl_multi.sv
// stepctl_multi: N-channel closed-loop step controller with stall detection and abort.
//
// Each channel moves its motor a commanded number of encoder ticks at a latched PWM
// duty and direction. It pulses done on normal completion, and it enters FAULT when no
// encoder edge arrives for STALL_CYC cycles while running.
//
// Ports (channel i uses bit i, or slice [i*W +: W] for the wide buses):
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   start      command strobe, accepted in IDLE only
//   abort      stop the move; also clears FAULT
//   ndegs      ticks to travel (CNT_W bits per channel)
//   speed      PWM on-cycles per period (16 bits per channel)
//   dir        requested direction, latched on an accepted start
//   encoder    raw asynchronous encoder pulses
//   pwm        PWM to the motor driver
//   motor_en   driver enable, high exactly while in RUN
//   motor_dir  latched direction
//   busy       high while in RUN
//   done       1-cycle pulse on normal completion
//   stall      high while in FAULT
module stepctl_multi #(
    parameter int unsigned NCH       = 2,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned PERIOD    = 16000,
    parameter int unsigned STALL_CYC = 1600000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       start,
    input  logic [NCH-1:0]       abort,
    input  logic [NCH*CNT_W-1:0] ndegs,
    input  logic [NCH*16-1:0]    speed,
    input  logic [NCH-1:0]       dir,
    input  logic [NCH-1:0]       encoder,
    output logic [NCH-1:0]       pwm,
    output logic [NCH-1:0]       motor_en,
    output logic [NCH-1:0]       motor_dir,
    output logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       done,
    output logic [NCH-1:0]       stall
);

    localparam int unsigned TMR_W  = $clog2(STALL_CYC + 1);
    localparam int unsigned PCNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(STALL_CYC - 1);
    localparam logic [TMR_W-1:0]  TMR_MAX   = '1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFault = 2'd2
    } state_e;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic             start_c, abort_c, dir_c;
        logic [CNT_W-1:0] ndegs_c;
        logic [15:0]      speed_c, speed_clamped;

        state_e            state_q, state_d;
        logic [CNT_W-1:0]  cnt_q, cnt_d;
        logic              dir_q, dir_d;
        logic [15:0]       spd_q, spd_d;
        logic [TMR_W-1:0]  tmr_q, tmr_d;
        logic [PCNT_W-1:0] pcnt_q, pcnt_d;
        logic              sync1_q, sync2_q, prev_q;
        logic              tick;
        logic              pwm_q, pwm_d;
        logic              run_q, run_d;
        logic              done_q, done_d;
        logic              stall_q, stall_d;

        assign start_c = start[i];
        assign abort_c = abort[i];
        assign dir_c   = dir[i];
        assign ndegs_c = ndegs[i*CNT_W +: CNT_W];
        assign speed_c = speed[i*16 +: 16];

        // Any duty at or above the period means "always on"; clamping keeps the compare simple.
        assign speed_clamped = (32'(speed_c) > PERIOD) ? 16'(PERIOD) : speed_c;

        // Rising edge of the synchronised encoder input.
        assign tick = sync2_q & ~prev_q;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            dir_d   = dir_q;
            spd_d   = spd_q;
            tmr_d   = tmr_q;
            pcnt_d  = pcnt_q;
            done_d  = 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (start_c && !abort_c) begin
                        if (ndegs_c == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = StRun;
                            cnt_d   = ndegs_c;
                            dir_d   = dir_c;
                            spd_d   = speed_clamped;
                            tmr_d   = '0;
                            pcnt_d  = '0;
                        end
                    end
                end
                StRun: begin
                    pcnt_d = (pcnt_q == PCNT_LAST) ? '0 : pcnt_q + 1'b1;
                    if (abort_c) begin
                        state_d = StIdle;
                    end else if (tick && cnt_q == CNT_ONE) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else if (!tick && tmr_q == TMR_LAST) begin
                        state_d = StFault;
                    end else if (tick) begin
                        cnt_d = cnt_q - 1'b1;
                        tmr_d = '0;
                    end else if (tmr_q != TMR_MAX) begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                StFault: begin
                    if (abort_c) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase

            // Outputs are registered from the next state so they change on the same edge.
            run_d   = (state_d == StRun);
            stall_d = (state_d == StFault);
            pwm_d   = run_d && (32'(pcnt_d) < 32'(spd_d));
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                dir_q   <= 1'b0;
                spd_q   <= '0;
                tmr_q   <= '0;
                pcnt_q  <= '0;
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                prev_q  <= 1'b0;
                pwm_q   <= 1'b0;
                run_q   <= 1'b0;
                done_q  <= 1'b0;
                stall_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                dir_q   <= dir_d;
                spd_q   <= spd_d;
                tmr_q   <= tmr_d;
                pcnt_q  <= pcnt_d;
                sync1_q <= encoder[i];
                sync2_q <= sync1_q;
                prev_q  <= sync2_q;
                pwm_q   <= pwm_d;
                run_q   <= run_d;
                done_q  <= done_d;
                stall_q <= stall_d;
            end
        end

        assign pwm[i]       = pwm_q;
        assign motor_en[i]  = run_q;
        assign busy[i]      = run_q;
        assign motor_dir[i] = dir_q;
        assign done[i]      = done_q;
        assign stall[i]     = stall_q;
    end

endmodule

// File: tb/tb_stepctl_multi.sv
// Self-checking bench for stepctl_multi (2 channels, PERIOD=10, STALL_CYC=100).
// Expected done cycles are queued per channel when stimulus is driven and checked
// against the DUT's done pulses by a monitor.
module tb_stepctl_multi;

    localparam int PER   = 10;
    localparam int STALL = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        st0 = 1'b0, st1 = 1'b0, ab0 = 1'b0, ab1 = 1'b0, en0 = 1'b0, en1 = 1'b0;
    logic [1:0]  dir_r = '0;
    logic [31:0] ndegs_r = '0;
    logic [31:0] speed_r = '0;
    logic [1:0]  start, abort, encoder;
    logic [1:0]  pwm, motor_en, motor_dir, busy, done, stall;
    logic [11:0] outs;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mon_e;
    int exp_q0[$];
    int exp_q1[$];
    int en_seen;

    assign start   = {st1, st0};
    assign abort   = {ab1, ab0};
    assign encoder = {en1, en0};
    assign outs    = {pwm, motor_en, motor_dir, busy, done, stall};

    stepctl_multi #(
        .NCH      (2),
        .CNT_W    (16),
        .PERIOD   (PER),
        .STALL_CYC(STALL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .ndegs    (ndegs_r),
        .speed    (speed_r),
        .dir      (dir_r),
        .encoder  (encoder),
        .pwm      (pwm),
        .motor_en (motor_en),
        .motor_dir(motor_dir),
        .busy     (busy),
        .done     (done),
        .stall    (stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Start strobe for one cycle; a zero-length move must answer with done one cycle later.
    task automatic start_ch(input int ch, input int nd, input int sp, input logic d);
        @(posedge clk);
        #1;
        ndegs_r[ch*16 +: 16] = nd[15:0];
        speed_r[ch*16 +: 16] = sp[15:0];
        dir_r[ch] = d;
        if (ch == 0) st0 = 1'b1; else st1 = 1'b1;
        if (nd == 0) begin
            if (ch == 0) exp_q0.push_back(cyc + 1); else exp_q1.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        if (ch == 0) st0 = 1'b0; else st1 = 1'b0;
    endtask

    // Encoder pulse: 2 cycles high, 2 low. A final tick completes 3 cycles after the raw edge.
    task automatic enc_pulse(input int ch, input bit last);
        @(posedge clk);
        #1;
        if (ch == 0) en0 = 1'b1; else en1 = 1'b1;
        if (last) begin
            if (ch == 0) exp_q0.push_back(cyc + 3); else exp_q1.push_back(cyc + 3);
        end
        repeat (2) @(posedge clk);
        #1;
        if (ch == 0) en0 = 1'b0; else en1 = 1'b0;
        @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < 2; c++) begin
                if (done[c]) begin
                    check("done_motor_en_low", int'(motor_en[c]), 0);
                    check("done_busy_low", int'(busy[c]), 0);
                    if (c == 0 && exp_q0.size() == 0) begin
                        check("done_unexpected_ch0", 1, 0);
                    end else if (c == 1 && exp_q1.size() == 0) begin
                        check("done_unexpected_ch1", 1, 0);
                    end else begin
                        mon_e = (c == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check("done_cycle", cyc, mon_e);
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs_low", int'(outs), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_reset_outs", int'(outs), 0);

        // 1: five ticks complete the move, sixth ignored; direction latched
        start_ch(0, 5, 2000, 1'b1);
        check("t1_busy", int'(busy[0]), 1);
        check("t1_motor_en", int'(motor_en[0]), 1);
        check("t1_dir", int'(motor_dir[0]), 1);
        check("t1_pwm_clamped", int'(pwm[0]), 1);
        dir_r[0] = 1'b0;
        for (int k = 1; k <= 6; k++) enc_pulse(0, k == 5);
        repeat (4) @(posedge clk);
        #1;
        check("t1_idle_after", int'(busy[0]), 0);
        check("t1_dir_held", int'(motor_dir[0]), 1);

        // 2: zero-length move
        en_seen = 0;
        start_ch(1, 0, 5, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (motor_en[1]) en_seen = 1;
            @(posedge clk);
            #1;
        end
        check("t2_motor_en_never", en_seen, 0);

        // 3: stall after STALL cycles in RUN, cleared by abort
        start_ch(0, 5, 2000, 1'b0);
        repeat (STALL - 1) @(posedge clk);
        #1;
        check("t3_busy_last", int'(busy[0]), 1);
        check("t3_stall_early", int'(stall[0]), 0);
        @(posedge clk);
        #1;
        check("t3_stall", int'(stall[0]), 1);
        check("t3_busy_fault", int'(busy[0]), 0);
        check("t3_pwm_fault", int'(pwm[0]), 0);
        check("t3_en_fault", int'(motor_en[0]), 0);
        ab0 = 1'b1;
        @(posedge clk);
        #1;
        ab0 = 1'b0;
        check("t3_stall_cleared", int'(stall[0]), 0);
        check("t3_busy_after_abort", int'(busy[0]), 0);

        // 4: two channels running concurrently
        fork
            begin
                start_ch(0, 10, 6, 1'b0);
                for (int k = 1; k <= 10; k++) enc_pulse(0, k == 10);
            end
            begin
                repeat (12) @(posedge clk);
                start_ch(1, 3, 6, 1'b1);
                check("t4_ch1_busy", int'(busy[1]), 1);
                for (int k = 1; k <= 3; k++) enc_pulse(1, k == 3);
                #1;
                check("t4_ch0_unaffected", int'(busy[0]), 1);
                check("t4_ch1_idle", int'(busy[1]), 0);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("t4_both_idle", int'(busy), 0);

        // 5: abort mid-move (no done), start+abort in IDLE ignored
        start_ch(0, 4, 6, 1'b0);
        enc_pulse(0, 1'b0);
        enc_pulse(0, 1'b0);
        #1;
        check("t5_busy_mid", int'(busy[0]), 1);
        ab0 = 1'b1;
        @(posedge clk);
        #1;
        ab0 = 1'b0;
        check("t5_aborted", int'(busy[0]), 0);
        enc_pulse(0, 1'b0);
        enc_pulse(0, 1'b0);
        @(posedge clk);
        #1;
        st0 = 1'b1;
        ab0 = 1'b1;
        @(posedge clk);
        #1;
        st0 = 1'b0;
        ab0 = 1'b0;
        check("t5_start_abort_idle", int'(busy[0]), 0);
        repeat (2) @(posedge clk);
        #1;
        check("t5_still_idle", int'(busy[0]), 0);

        // 6: PWM pattern 1111000000 from RUN entry, then reset mid-move
        start_ch(1, 3, 4, 1'b1);
        for (int k = 0; k < 2 * PER; k++) begin
            check("t6_pwm", int'(pwm[1]), ((k % PER) < 4) ? 1 : 0);
            @(posedge clk);
            #1;
        end
        check("t6_busy_before_reset", int'(busy[1]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_reset_outs_low", int'(outs), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t6_idle_after_reset", int'(outs), 0);

        check("sb_empty_ch0", exp_q0.size(), 0);
        check("sb_empty_ch1", exp_q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule
